// File: rtl/fir_seq_pkg.sv
// Shared types and defaults for the FIR stream sequencer.
// State encoding plus sample/result widths.
package fir_seq_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int OUT_W_DEF  = 32;
  localparam int UCNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RUN,
    DRAIN
  } state_t;
endpackage

// File: rtl/fir_sample_fifo.sv
// Ingress sample FIFO, first-word fall-through.
// Pointers wrap modulo the power-of-2 depth.
module fir_sample_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic              wr;
  logic              rd;

  assign wr    = push && !clr;
  assign rd    = pop && !clr;
  assign dout  = mem[rptr];
  assign full  = (cnt == CW'(FIFO_DEPTH));
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      if (wr && !rd)      cnt <= cnt + 1'b1;
      else if (rd && !wr) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/fir_stream_sequencer.sv
// Feeds a free-running FIR from a buffered stream and
// re-qualifies its output with a delayed tag.
module fir_stream_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int NUM_TAPS    = 16,
  parameter int FIR_LATENCY = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] fir_data,
  input  logic [OUT_W-1:0]  fir_result,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_valid,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt,
  output logic              busy
);
  localparam int ZW = $clog2(NUM_TAPS + 1);

  state_t              state;
  state_t              nstate;
  logic [ZW-1:0]       zcnt;
  logic                zload;
  logic                zdec;
  logic                pop;
  logic                push;
  logic                fclr;
  logic                full;
  logic                empty;
  logic [DATA_W-1:0]   dout;
  logic [DATA_W-1:0]   nxt_data;
  logic                nxt_tag;
  logic                urun;
  logic                cclr;
  logic [FIR_LATENCY:0] tp;

  fir_sample_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .clr  (fclr),
    .push (push),
    .pop  (pop),
    .din  (s_data),
    .dout (dout),
    .full (full),
    .empty(empty)
  );

  // a full FIFO still accepts when the head leaves this cycle
  assign s_ready = !reset && (state == FLUSH || state == RUN)
                   && (!full || pop);
  assign push    = s_valid && s_ready;
  assign busy    = (state != IDLE);

  always_comb begin
    nstate   = state;
    zload    = 1'b0;
    zdec     = 1'b0;
    pop      = 1'b0;
    fclr     = 1'b0;
    nxt_data = '0;
    nxt_tag  = 1'b0;
    urun     = 1'b0;
    cclr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          nstate = FLUSH;
          zload  = 1'b1;
          cclr   = 1'b1;
        end
      end
      FLUSH: begin
        if (stop) begin
          nstate = IDLE;
          fclr   = 1'b1;
        end else if (zcnt == '0) begin
          nstate = RUN;
        end else begin
          zdec = 1'b1;
        end
      end
      RUN: begin
        nxt_tag = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          nxt_data = dout;
        end else begin
          urun = 1'b1;
        end
        if (stop) begin
          nstate = DRAIN;
          zload  = 1'b1;
        end
      end
      DRAIN: begin
        nxt_tag = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          nxt_data = dout;
        end else if (zcnt == '0) begin
          nstate = IDLE;
        end else begin
          zdec = 1'b1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      zcnt         <= '0;
      fir_data     <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      tp           <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
    end else begin
      state    <= nstate;
      fir_data <= nxt_data;
      underrun <= urun;
      tp       <= {tp[FIR_LATENCY-1:0], nxt_tag};
      m_valid  <= tp[FIR_LATENCY];
      if (tp[FIR_LATENCY]) m_data <= fir_result;
      if (zload)     zcnt <= ZW'(NUM_TAPS - 1);
      else if (zdec) zcnt <= zcnt - 1'b1;
      if (cclr)
        underrun_cnt <= '0;
      else if (urun && underrun_cnt != '1)
        underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Scoreboard bench: bench-side FIR with taps h[k]=k+1,
// expected results queued at stimulus time.
module tb_fir_stream_sequencer;
  localparam int NT  = 16;
  localparam int LAT = 3;

  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic        stop = 0;
  logic [15:0] s_data = 0;
  logic        s_valid = 0;
  logic        s_ready;
  logic [15:0] fir_data;
  logic [31:0] fir_result;
  logic [31:0] m_data;
  logic        m_valid;
  logic        underrun;
  logic [15:0] underrun_cnt;
  logic        busy;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int tl[$];
  int smp[$];
  int ncyc = 0;
  int first_mv = 0;
  int drain_cyc = 0;
  int e;

  fir_stream_sequencer #(
    .DATA_W(16), .OUT_W(32), .NUM_TAPS(NT),
    .FIR_LATENCY(LAT), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .fir_data(fir_data), .fir_result(fir_result),
    .m_data(m_data), .m_valid(m_valid), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // free-running FIR model, LAT cycles from input to output
  logic signed [15:0] hist [NT-1];
  int dly [LAT];
  int conv;
  initial begin
    for (int k = 0; k < NT-1; k++) hist[k] = 0;
    for (int k = 0; k < LAT; k++) dly[k] = 0;
  end
  always_comb begin
    conv = int'($signed(fir_data));
    for (int k = 1; k < NT; k++)
      conv = conv + (k + 1) * int'(hist[k-1]);
  end
  always @(posedge clk) begin
    hist[0] <= $signed(fir_data);
    for (int k = 1; k < NT-1; k++) hist[k] <= hist[k-1];
    dly[0] <= conv;
    for (int k = 1; k < LAT; k++) dly[k] <= dly[k-1];
  end
  assign fir_result = dly[LAT-1];

  // monitor
  always @(negedge clk) begin
    if (m_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL m_out unexpected valid m_data=%0d", $signed(m_data));
      end else begin
        e = exp_q.pop_front();
        if ($signed(m_data) !== e) begin
          bad++;
          $display("FAIL m_data got=%0d want=%0d", $signed(m_data), e);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, ex);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    ncyc++;
    if (m_valid === 1'b1 && first_mv == 0) first_mv = ncyc;
  endtask

  // expected outputs: convolution of tagged stream, zero history
  task automatic push_expected();
    int y;
    for (int j = 0; j < tl.size(); j++) begin
      y = 0;
      for (int k = 0; k < NT; k++)
        if (j - k >= 0) y = y + (k + 1) * tl[j-k];
      exp_q.push_back(y);
    end
  endtask

  task automatic do_start();
    start = 1;
    first_mv = 0;
    ncyc = 0;
    cyc();
    start = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      cyc();
      k++;
    end
    drain_cyc = k;
    chk("idle_timeout", {31'd0, busy}, 0);
    repeat (8) cyc();
  endtask

  task automatic run_stream();
    int idx = 0;
    bit acc;
    tl = smp;
    repeat (NT) tl.push_back(0);
    push_expected();
    while (!(idx == smp.size() && ncyc >= 17) && ncyc < 300) begin
      s_valid = (idx < smp.size());
      s_data  = s_valid ? 16'(smp[idx]) : 16'd0;
      acc = s_valid && s_ready;
      cyc();
      if (acc) idx++;
    end
    s_valid = 0;
    s_data  = 0;
    stop = 1;
    cyc();
    stop = 0;
    chk("drain_ready", {31'd0, s_ready}, 0);
    chk("drain_busy", {31'd0, busy}, 1);
    wait_idle();
    chk("first_valid_cycle", first_mv, 22);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  task automatic basic_run();
    do_start();
    chk("flush_ready", {31'd0, s_ready}, 1);
    smp = {16'h4000};
    repeat (23) smp.push_back(0);
    run_stream();
    chk("basic_ucnt", {16'd0, underrun_cnt}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) cyc();
    reset = 0;
    chk("rst_fir_data", {16'd0, fir_data}, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_ucnt", {16'd0, underrun_cnt}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_s_ready", {31'd0, s_ready}, 0);

    // basic impulse run
    basic_run();

    // underrun: 3-cycle gap in RUN
    do_start();
    tl = {1, 2, 3, 4, 5, 0, 0, 0, 6, 7};
    repeat (NT) tl.push_back(0);
    push_expected();
    for (int n = 1; n <= 30; n++) begin
      if (n == 22) begin
        chk("ur_before", {31'd0, underrun}, 0);
        chk("ur_before_data", {16'd0, fir_data}, 5);
      end
      if (n >= 23 && n <= 25) begin
        chk("ur_pulse", {31'd0, underrun}, 1);
        chk("ur_zero", {16'd0, fir_data}, 0);
      end
      if (n == 26) begin
        chk("ur_after", {31'd0, underrun}, 0);
        chk("ur_after_data", {16'd0, fir_data}, 6);
        chk("ur_cnt", {16'd0, underrun_cnt}, 3);
      end
      if (n >= 27 && n <= 29)
        chk("ur_m_valid", {31'd0, m_valid}, 1);
      s_valid = (n >= 16 && n <= 20) || n == 24 || n == 25;
      s_data  = (n >= 16 && n <= 20) ? 16'(n - 15) :
                (n == 24) ? 16'd6 : (n == 25) ? 16'd7 : 16'd0;
      stop = (n == 26);
      cyc();
    end
    s_valid = 0;
    stop = 0;
    wait_idle();
    chk("ur_first_valid", first_mv, 22);
    chk("ur_sb_empty", exp_q.size(), 0);
    chk("ur_cnt_drain", {16'd0, underrun_cnt}, 3);

    // stop with a full backlog
    do_start();
    smp = {100, -100, 200, -200};
    run_stream();
    chk("backlog_drain_len", drain_cyc, 19);

    // full FIFO with simultaneous pop/push: ramp
    do_start();
    smp = {};
    for (int i = 0; i < 32; i++) smp.push_back(i);
    run_stream();
    chk("ramp_ucnt", {16'd0, underrun_cnt}, 0);

    // start and stop together in IDLE
    start = 1;
    stop = 1;
    cyc();
    start = 0;
    stop = 0;
    chk("ss_busy", {31'd0, busy}, 0);
    cyc();
    chk("ss_busy2", {31'd0, busy}, 0);
    chk("ss_ready", {31'd0, s_ready}, 0);

    // stop during FLUSH with prefilled FIFO
    do_start();
    for (int n = 1; n <= 5; n++) begin
      s_valid = (n <= 2);
      s_data  = 16'd55;
      stop = (n == 5);
      cyc();
    end
    s_valid = 0;
    stop = 0;
    chk("fstop_busy", {31'd0, busy}, 0);
    chk("fstop_ready", {31'd0, s_ready}, 0);
    repeat (25) cyc();
    chk("fstop_no_valid", first_mv, 0);
    do_start();
    smp = {9};
    run_stream();

    // reset mid-RUN
    do_start();
    tl = {7, 0, 0, 0};
    push_expected();
    for (int n = 1; n <= 25; n++) begin
      if (n == 25) begin
        chk("mr_ucnt", {16'd0, underrun_cnt}, 7);
        chk("mr_underrun", {31'd0, underrun}, 1);
        chk("mr_m_data", m_data, 28);
        chk("mr_m_valid", {31'd0, m_valid}, 1);
      end
      s_valid = (n == 1);
      s_data  = 16'd7;
      reset = (n == 25);
      cyc();
    end
    reset = 0;
    s_valid = 0;
    chk("mr_fir_data", {16'd0, fir_data}, 0);
    chk("mr_m_data0", m_data, 0);
    chk("mr_m_valid0", {31'd0, m_valid}, 0);
    chk("mr_underrun0", {31'd0, underrun}, 0);
    chk("mr_ucnt0", {16'd0, underrun_cnt}, 0);
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_ready", {31'd0, s_ready}, 0);
    repeat (8) cyc();
    chk("mr_sb_empty", exp_q.size(), 0);
    basic_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
